// File: rtl/alu_exception_unit.sv
// Precise-trap unit for the EX stage: turns enabled ALU faults into a flush plus
// a fetch redirect to the handler vector, records EPC/Cause/BadVAddr, and resumes on ERET.
module alu_exception_unit #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h8000_0180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  ALU_status,
  input  logic [31:0] ALU_result,
  input  logic        status_valid,
  input  logic [31:0] pc_ex,
  input  logic        chk_ovf,
  input  logic        chk_addr,
  input  logic        is_store,
  input  logic        chk_div,
  input  logic        eret,
  output logic        exc_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [31:0] cause,
  output logic [31:0] badvaddr,
  output logic        in_handler,
  output logic        double_fault
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_FLUSH   = 2'b01;
  localparam logic [1:0] ST_HANDLER = 2'b10;

  localparam logic [4:0] EXC_LOAD  = 5'd4;
  localparam logic [4:0] EXC_STORE = 5'd5;
  localparam logic [4:0] EXC_OVF   = 5'd12;
  localparam logic [4:0] EXC_DIV   = 5'd15;

  // Trap edge counts as the first flush cycle, so the counter starts one short.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  function automatic logic [4:0] exc_code(input logic div_hit, input logic addr_hit,
                                          input logic store);
    logic [4:0] code;
    if (div_hit) begin
      code = EXC_DIV;
    end else if (addr_hit) begin
      code = store ? EXC_STORE : EXC_LOAD;
    end else begin
      code = EXC_OVF;
    end
    return code;
  endfunction

  logic        div_hit_s, addr_hit_s, ovf_hit_s, fault_s;
  logic        unused_status_s;
  logic [4:0]  code_s;

  logic [1:0]  state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        exc_flush_q, exc_flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        in_handler_q, in_handler_d;
  logic        double_fault_q, double_fault_d;

  assign div_hit_s       = chk_div  & ALU_status[2];
  assign addr_hit_s      = chk_addr & ALU_status[3];
  assign ovf_hit_s       = chk_ovf  & ALU_status[6];
  assign fault_s         = status_valid & (div_hit_s | addr_hit_s | ovf_hit_s);
  assign code_s          = exc_code(div_hit_s, addr_hit_s, is_store);
  assign unused_status_s = ^{ALU_status[7], ALU_status[5:4], ALU_status[1:0]};

  // Next-state and output computation for the trap FSM.
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    exc_flush_d      = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    badvaddr_d       = badvaddr_q;
    in_handler_d     = in_handler_q;
    double_fault_d   = double_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (fault_s) begin
          state_d          = ST_FLUSH;
          flush_cnt_d      = FLUSH_INIT;
          exc_flush_d      = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = VECTOR_ADDR;
          epc_d            = pc_ex;
          cause_d          = {25'd0, code_s, 2'b00};
          in_handler_d     = 1'b1;
          if (!div_hit_s && addr_hit_s) begin
            badvaddr_d = ALU_result;
          end else begin
            badvaddr_d = badvaddr_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d     = ST_HANDLER;
          exc_flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          exc_flush_d = 1'b1;
        end
      end
      ST_HANDLER: begin
        if (eret) begin
          state_d          = ST_IDLE;
          exc_flush_d      = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = epc_q;
          in_handler_d     = 1'b0;
        end else if (fault_s) begin
          double_fault_d = 1'b1;
        end else begin
          state_d = ST_HANDLER;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        in_handler_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      flush_cnt_q      <= 4'd0;
      exc_flush_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      epc_q            <= 32'd0;
      cause_q          <= 32'd0;
      badvaddr_q       <= 32'd0;
      in_handler_q     <= 1'b0;
      double_fault_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      exc_flush_q      <= exc_flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      epc_q            <= epc_d;
      cause_q          <= cause_d;
      badvaddr_q       <= badvaddr_d;
      in_handler_q     <= in_handler_d;
      double_fault_q   <= double_fault_d;
    end
  end

  assign exc_flush      = exc_flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign badvaddr       = badvaddr_q;
  assign in_handler     = in_handler_q;
  assign double_fault   = double_fault_q;

endmodule
